// File: rtl/pattern_apply_sequencer_if.sv
// Bus between the pattern sequencer and its controller / netlist-under-test.
// state_dbg encoding: 0 IDLE, 1 APPLY, 2 SETTLE, 3 CAPTURE, 4 DONE.
interface pattern_apply_sequencer_if #(
    parameter int IN_W  = 11,
    parameter int OUT_W = 9
);
    // start and abort are level requests sampled on the rising clock edge with no ack:
    // start is honoured only while idle, abort only while a run is active.
    logic             start;
    logic             abort;
    logic [OUT_W-1:0] dut_out;
    logic [IN_W-1:0]  dut_in;
    logic             busy;
    logic             done;
    logic             sig_valid;
    logic [15:0]      signature;
    logic [15:0]      vec_idx;
    logic             pass;
    logic [2:0]       state_dbg;

    modport master (output start, abort, dut_out,
                    input  dut_in, busy, done, sig_valid, signature, vec_idx, pass, state_dbg);
    modport slave  (input  start, abort, dut_out,
                    output dut_in, busy, done, sig_valid, signature, vec_idx, pass, state_dbg);
endinterface

// File: rtl/pattern_apply_sequencer.sv
// LFSR pattern applier with MISR response compaction for self-test of a netlist.
// Defining PATSEQ_GOLDEN_CHECK_EN adds a golden-signature compare driving pass.
module pattern_apply_sequencer #(
    parameter int          IN_W       = 11,
    parameter int          OUT_W      = 9,
    parameter int          SETTLE     = 2,
    parameter int          NUM_VEC    = 256,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
    input  logic                     blif_clk_net,
    input  logic                     blif_reset_net,
    pattern_apply_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_APPLY   = 3'd1,
        S_SETTLE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] LAST_IDX  = 16'(NUM_VEC - 1);
    localparam logic [7:0]  SETTLE_LD = (SETTLE > 0) ? 8'(SETTLE - 1) : 8'd0;

    state_t          state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [15:0]     misr_q, misr_d;
    logic [15:0]     vec_idx_q, vec_idx_d;
    logic [IN_W-1:0] dut_in_q, dut_in_d;
    logic [7:0]      settle_cnt_q, settle_cnt_d;
    logic            sig_valid_q, sig_valid_d;
    logic [15:0]     lfsr_step, misr_step;
    logic            abort_hit, start_hit, last_capture;

    assign lfsr_step    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign misr_step    = {misr_q[14:0], misr_q[15] ^ misr_q[13] ^ misr_q[12] ^ misr_q[10]}
                          ^ 16'(bus.dut_out);
    assign abort_hit    = bus.abort && (state_q != S_IDLE);
    assign start_hit    = bus.start && (state_q == S_IDLE);
    assign last_capture = (state_q == S_CAPTURE) && (vec_idx_q == LAST_IDX) && !abort_hit;

    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            state_q      <= S_IDLE;
            lfsr_q       <= SEED_EFF;
            misr_q       <= '0;
            vec_idx_q    <= '0;
            dut_in_q     <= '0;
            settle_cnt_q <= '0;
            sig_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            misr_q       <= misr_d;
            vec_idx_q    <= vec_idx_d;
            dut_in_q     <= dut_in_d;
            settle_cnt_q <= settle_cnt_d;
            sig_valid_q  <= sig_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        misr_d       = misr_q;
        vec_idx_d    = vec_idx_q;
        dut_in_d     = dut_in_q;
        settle_cnt_d = settle_cnt_q;
        sig_valid_d  = sig_valid_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d     = S_APPLY;
                    lfsr_d      = SEED_EFF;
                    misr_d      = '0;
                    vec_idx_d   = '0;
                    sig_valid_d = 1'b0;
                end
            end
            S_APPLY: begin
                dut_in_d     = lfsr_q[IN_W-1:0];
                settle_cnt_d = SETTLE_LD;
                state_d      = (SETTLE > 0) ? S_SETTLE : S_CAPTURE;
            end
            S_SETTLE: begin
                if (settle_cnt_q == 8'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    settle_cnt_d = settle_cnt_q - 8'd1;
                end
            end
            S_CAPTURE: begin
                misr_d = misr_step;
                lfsr_d = lfsr_step;
                if (vec_idx_q == LAST_IDX) begin
                    state_d     = S_DONE;
                    sig_valid_d = 1'b1;
                end else begin
                    vec_idx_d = vec_idx_q + 16'd1;
                    state_d   = S_APPLY;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort wins over everything in the case above, including the capture update.
        if (abort_hit) begin
            state_d     = S_IDLE;
            dut_in_d    = '0;
            misr_d      = misr_q;
            lfsr_d      = lfsr_q;
            vec_idx_d   = vec_idx_q;
            sig_valid_d = 1'b0;
        end
    end

    assign bus.dut_in    = dut_in_q;
    assign bus.busy      = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_CAPTURE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.sig_valid = sig_valid_q;
    assign bus.signature = misr_q;
    assign bus.vec_idx   = vec_idx_q;
    assign bus.state_dbg = state_q;

`ifdef PATSEQ_GOLDEN_CHECK_EN
    logic pass_q;

    // Compares the signature being written by the final capture, so pass lines up with done.
    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            pass_q <= 1'b0;
        end else if (abort_hit || start_hit) begin
            pass_q <= 1'b0;
        end else if (last_capture) begin
            pass_q <= (misr_step == GOLDEN_SIG);
        end
    end

    assign bus.pass = pass_q;
`else
    // GOLDEN_SIG is still referenced so the parameter list stays uniform; this folds to 0.
    assign bus.pass = 1'b0 & (^GOLDEN_SIG);
`endif
endmodule

// File: tb/tb_pattern_apply_sequencer.sv
// Self-checking bench for pattern_apply_sequencer: three instances with different run shapes
// checked against a plain-arithmetic LFSR/MISR reference model.
module tb_pattern_apply_sequencer;
    localparam logic [15:0] SEED_A = 16'h0001;
    localparam logic [15:0] SEED_B = 16'hACE1;
    localparam logic [15:0] SEED_C = 16'hACE1;
`ifdef PATSEQ_GOLDEN_CHECK_EN
    localparam bit GOLD_EN = 1'b1;
`else
    localparam bit GOLD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] exp_q[$];

    int         a_mul = 0, b_mul = 0, c_mul = 0;
    logic [8:0] a_salt = '0, b_salt = '0, c_salt = '0;

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model
    function automatic logic [15:0] step16(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    function automatic logic [8:0] dut_fn(input logic [10:0] din, input int mul, input logic [8:0] salt);
        int prod;
        prod = int'(din) * mul;
        return 9'(prod) ^ salt;
    endfunction

    function automatic logic [15:0] model_sig(input logic [15:0] seed, input int nvec,
                                              input int mul, input logic [8:0] salt);
        logic [15:0] l;
        logic [15:0] m;
        l = (seed == 16'h0000) ? 16'h0001 : seed;
        m = '0;
        for (int v = 0; v < nvec; v++) begin
            m = step16(m) ^ {7'd0, dut_fn(l[10:0], mul, salt)};
            l = step16(l);
        end
        return m;
    endfunction

    task automatic fill_exp(input logic [15:0] seed, input int nvec);
        logic [15:0] l;
        exp_q.delete();
        l = seed;
        for (int v = 0; v < nvec; v++) begin
            exp_q.push_back(l);
            l = step16(l);
        end
    endtask

    pattern_apply_sequencer_if #(.IN_W(11), .OUT_W(9)) if_a ();
    pattern_apply_sequencer_if #(.IN_W(11), .OUT_W(9)) if_b ();
    pattern_apply_sequencer_if #(.IN_W(11), .OUT_W(9)) if_c ();

    assign if_a.dut_out = dut_fn(if_a.dut_in, a_mul, a_salt);
    assign if_b.dut_out = dut_fn(if_b.dut_in, b_mul, b_salt);
    assign if_c.dut_out = dut_fn(if_c.dut_in, c_mul, c_salt);

    pattern_apply_sequencer #(.IN_W(11), .OUT_W(9), .SETTLE(2), .NUM_VEC(4),
                              .LFSR_SEED(SEED_A), .GOLDEN_SIG(16'h0000))
        dut_a (.blif_clk_net(clk), .blif_reset_net(rst), .bus(if_a.slave));
    pattern_apply_sequencer #(.IN_W(11), .OUT_W(9), .SETTLE(0), .NUM_VEC(1),
                              .LFSR_SEED(SEED_B), .GOLDEN_SIG(16'h01A5))
        dut_b (.blif_clk_net(clk), .blif_reset_net(rst), .bus(if_b.slave));
    pattern_apply_sequencer #(.IN_W(11), .OUT_W(9), .SETTLE(2), .NUM_VEC(256),
                              .LFSR_SEED(SEED_C), .GOLDEN_SIG(16'h0000))
        dut_c (.blif_clk_net(clk), .blif_reset_net(rst), .bus(if_c.slave));

    logic [49:0] a_obs, b_obs, c_obs;
    assign a_obs = {if_a.dut_in, if_a.busy, if_a.done, if_a.sig_valid, if_a.signature,
                    if_a.vec_idx, if_a.pass, if_a.state_dbg};
    assign b_obs = {if_b.dut_in, if_b.busy, if_b.done, if_b.sig_valid, if_b.signature,
                    if_b.vec_idx, if_b.pass, if_b.state_dbg};
    assign c_obs = {if_c.dut_in, if_c.busy, if_c.done, if_c.sig_valid, if_c.signature,
                    if_c.vec_idx, if_c.pass, if_c.state_dbg};

    // driver tasks with inline checks
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (a_obs !== '0) begin errors++; $display("FAIL reset_a obs=%h exp=0", a_obs); end
        checks++; if (b_obs !== '0) begin errors++; $display("FAIL reset_b obs=%h exp=0", b_obs); end
        checks++; if (c_obs !== '0) begin errors++; $display("FAIL reset_c obs=%h exp=0", c_obs); end
        rst = 1'b0;
        if_a.start = 1'b1; if_b.start = 1'b1; if_c.start = 1'b1;
        tick();
        if_a.start = 1'b0; if_b.start = 1'b0; if_c.start = 1'b0;
        repeat (4) tick();
        checks++; if (if_a.busy !== 1'b1) begin errors++; $display("FAIL prereset_busy got=%b exp=1", if_a.busy); end
        checks++; if (if_b.sig_valid !== 1'b1) begin errors++; $display("FAIL prereset_sigv got=%b exp=1", if_b.sig_valid); end
        rst = 1'b1; if_a.start = 1'b1; if_a.abort = 1'b1; if_c.start = 1'b1;
        tick();
        checks++; if (a_obs !== '0) begin errors++; $display("FAIL midreset_a obs=%h exp=0", a_obs); end
        checks++; if (b_obs !== '0) begin errors++; $display("FAIL midreset_b obs=%h exp=0", b_obs); end
        checks++; if (c_obs !== '0) begin errors++; $display("FAIL midreset_c obs=%h exp=0", c_obs); end
        tick();
        rst = 1'b0; if_a.start = 1'b0; if_a.abort = 1'b0; if_c.start = 1'b0;
        tick();
        checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL postreset_a_busy got=%b exp=0", if_a.busy); end
        checks++; if (if_c.busy !== 1'b0) begin errors++; $display("FAIL postreset_c_busy got=%b exp=0", if_c.busy); end
    endtask

    task automatic test_stimulus_seq();
        logic [10:0] seq [0:2];
        int v;
        seq[0] = 11'h001; seq[1] = 11'h002; seq[2] = 11'h004;
        a_mul = int'($urandom_range(1, 50)); a_salt = 9'($urandom);
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            v = (c - 1) / 4;
            if (v < 3 && ((c - 1) % 4) >= 1) begin
                checks++;
                if (if_a.dut_in !== seq[v]) begin
                    errors++; $display("FAIL stim_seq v%0d c%0d got=%h exp=%h", v, c, if_a.dut_in, seq[v]);
                end
            end
            tick();
        end
    endtask

    task automatic test_run_timing();
        a_mul = 0; a_salt = '0;
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            checks++; if (if_a.busy !== (c <= 16)) begin errors++; $display("FAIL timing_busy c%0d got=%b", c, if_a.busy); end
            checks++; if (if_a.done !== (c == 17)) begin errors++; $display("FAIL timing_done c%0d got=%b", c, if_a.done); end
            if (c >= 18) begin
                checks++; if (if_a.sig_valid !== 1'b1) begin errors++; $display("FAIL timing_sigv c%0d got=%b exp=1", c, if_a.sig_valid); end
                checks++; if (if_a.signature !== 16'h0000) begin errors++; $display("FAIL timing_sig c%0d got=%h exp=0000", c, if_a.signature); end
            end
            // starts during a run and in the DONE cycle must be ignored
            if_a.start = (c == 5) || (c == 17);
            tick();
        end
        if_a.start = 1'b0;
    endtask

    task automatic test_single_vector();
        logic [8:0]  salts [0:2];
        logic [15:0] exp_sig;
        salts[0] = 9'h1A5; salts[1] = 9'h1A4; salts[2] = 9'($urandom);
        for (int r = 0; r < 3; r++) begin
            b_mul = (r == 2) ? int'($urandom_range(1, 300)) : 0;
            b_salt = salts[r];
            exp_sig = model_sig(SEED_B, 1, b_mul, b_salt);
            if_b.start = 1'b1;
            tick();
            if_b.start = 1'b0;
            for (int c = 1; c <= 4; c++) begin
                checks++; if (if_b.busy !== (c <= 2)) begin errors++; $display("FAIL single_busy r%0d c%0d got=%b", r, c, if_b.busy); end
                checks++; if (if_b.done !== (c == 3)) begin errors++; $display("FAIL single_done r%0d c%0d got=%b", r, c, if_b.done); end
                if (c == 1) begin
                    checks++; if ({if_b.pass, if_b.sig_valid, if_b.signature} !== 18'd0) begin
                        errors++; $display("FAIL single_clear r%0d got=%b%b%h exp=0", r, if_b.pass, if_b.sig_valid, if_b.signature);
                    end
                end
                if (c == 4) begin
                    checks++; if (if_b.signature !== exp_sig) begin errors++; $display("FAIL single_sig r%0d got=%h exp=%h", r, if_b.signature, exp_sig); end
                    checks++; if (if_b.sig_valid !== 1'b1) begin errors++; $display("FAIL single_sigv r%0d got=%b exp=1", r, if_b.sig_valid); end
                    checks++; if (if_b.pass !== (GOLD_EN && exp_sig == 16'h01A5)) begin
                        errors++; $display("FAIL single_pass r%0d got=%b exp=%b", r, if_b.pass, GOLD_EN && exp_sig == 16'h01A5);
                    end
                end
                tick();
            end
        end
    endtask

    task automatic run_a_full(input int mul, input logic [8:0] salt);
        logic [15:0] exp_sig;
        logic [15:0] e;
        a_mul = mul; a_salt = salt;
        fill_exp(SEED_A, 4);
        exp_sig = model_sig(SEED_A, 4, mul, salt);
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            if (c % 4 == 0) begin
                e = exp_q.pop_front();
                checks++; if (if_a.dut_in !== e[10:0]) begin errors++; $display("FAIL runa_din c%0d got=%h exp=%h", c, if_a.dut_in, e[10:0]); end
                checks++; if (if_a.vec_idx !== 16'(c / 4 - 1)) begin errors++; $display("FAIL runa_idx c%0d got=%0d exp=%0d", c, if_a.vec_idx, c / 4 - 1); end
            end
            if (c <= 16) begin
                checks++; if (if_a.busy !== 1'b1) begin errors++; $display("FAIL runa_busy c%0d got=%b exp=1", c, if_a.busy); end
            end else begin
                checks++; if (if_a.done !== 1'b1) begin errors++; $display("FAIL runa_done got=%b exp=1", if_a.done); end
                checks++; if (if_a.signature !== exp_sig) begin errors++; $display("FAIL runa_sig got=%h exp=%h", if_a.signature, exp_sig); end
            end
            tick();
        end
        checks++; if ({if_a.sig_valid, if_a.busy} !== 2'b10) begin errors++; $display("FAIL runa_end sigv_busy got=%b%b exp=10", if_a.sig_valid, if_a.busy); end
    endtask

    task automatic abort_at(input int ac);
        logic [15:0] exp_sig;
        int n;
        a_mul = int'($urandom_range(1, 200)); a_salt = 9'($urandom_range(1, 511));
        n = (ac - 1) / 4;
        exp_sig = model_sig(SEED_A, n, a_mul, a_salt);
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        for (int c = 1; c <= ac; c++) begin
            checks++; if (if_a.done !== 1'b0) begin errors++; $display("FAIL abort_done ac%0d c%0d got=%b exp=0", ac, c, if_a.done); end
            if_a.abort = (c == ac);
            tick();
        end
        if_a.abort = 1'b0;
        checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL abort_busy ac%0d got=%b exp=0", ac, if_a.busy); end
        checks++; if (if_a.dut_in !== 11'h000) begin errors++; $display("FAIL abort_din ac%0d got=%h exp=000", ac, if_a.dut_in); end
        checks++; if (if_a.sig_valid !== 1'b0) begin errors++; $display("FAIL abort_sigv ac%0d got=%b exp=0", ac, if_a.sig_valid); end
        checks++; if (if_a.signature !== exp_sig) begin errors++; $display("FAIL abort_sig ac%0d got=%h exp=%h", ac, if_a.signature, exp_sig); end
        checks++; if (if_a.vec_idx !== 16'(n)) begin errors++; $display("FAIL abort_idx ac%0d got=%0d exp=%0d", ac, if_a.vec_idx, n); end
        tick();
        checks++; if ({if_a.done, if_a.busy} !== 2'b00) begin errors++; $display("FAIL abort_idle ac%0d got=%b%b exp=00", ac, if_a.done, if_a.busy); end
    endtask

    task automatic test_abort();
        abort_at(6);
        run_a_full(int'($urandom_range(1, 200)), 9'($urandom));
        abort_at(int'($urandom_range(1, 16)));
        run_a_full(int'($urandom_range(1, 200)), 9'($urandom));
        abort_at(16);
        run_a_full(int'($urandom_range(1, 200)), 9'($urandom));
        // abort while idle must not block a simultaneous start
        if_a.abort = 1'b1; if_a.start = 1'b1;
        tick();
        if_a.abort = 1'b0; if_a.start = 1'b0;
        checks++; if (if_a.busy !== 1'b1) begin errors++; $display("FAIL idle_abort_busy got=%b exp=1", if_a.busy); end
        repeat (16) tick();
        checks++; if (if_a.done !== 1'b1) begin errors++; $display("FAIL idle_abort_done got=%b exp=1", if_a.done); end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++) begin
            run_a_full(int'($urandom_range(0, 1000)), 9'($urandom));
        end
    endtask

    task automatic test_random_long();
        logic [15:0] exp_sig;
        logic [15:0] e;
        c_mul = int'($urandom_range(1, 1000)); c_salt = 9'($urandom);
        fill_exp(SEED_C, 256);
        exp_sig = model_sig(SEED_C, 256, c_mul, c_salt);
        if_c.start = 1'b1;
        tick();
        if_c.start = 1'b0;
        for (int c = 1; c <= 1026; c++) begin
            if (c % 4 == 0 && c <= 1024) begin
                e = exp_q.pop_front();
                checks++; if (if_c.dut_in !== e[10:0]) begin errors++; $display("FAIL long_din c%0d got=%h exp=%h", c, if_c.dut_in, e[10:0]); end
                checks++; if (if_c.vec_idx !== 16'(c / 4 - 1)) begin errors++; $display("FAIL long_idx c%0d got=%0d exp=%0d", c, if_c.vec_idx, c / 4 - 1); end
            end
            checks++; if (if_c.done !== (c == 1025)) begin errors++; $display("FAIL long_done c%0d got=%b", c, if_c.done); end
            if (c == 1025) begin
                checks++; if (if_c.signature !== exp_sig) begin errors++; $display("FAIL long_sig got=%h exp=%h", if_c.signature, exp_sig); end
            end
            tick();
        end
        checks++; if ({if_c.sig_valid, if_c.busy} !== 2'b10) begin errors++; $display("FAIL long_end sigv_busy got=%b%b exp=10", if_c.sig_valid, if_c.busy); end
    endtask

    initial begin
        if_a.start = 1'b0; if_a.abort = 1'b0;
        if_b.start = 1'b0; if_b.abort = 1'b0;
        if_c.start = 1'b0; if_c.abort = 1'b0;
        b_salt = 9'h0F0;
        test_reset();
        test_stimulus_seq();
        test_run_timing();
        test_single_vector();
        test_abort();
        test_back_to_back();
        test_random_long();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
